// File: rtl/sin_pwm_pkg.sv
// Shared widths, midscale constant and the sample-to-duty mapping for sin_pwm_dac.
// The default widths here are also the default parameters of the design.
package sin_pwm_pkg;

   localparam int SPW_DATA_W = 16;
   localparam int SPW_CNT_W  = 8;
   localparam int FRAC_W     = SPW_DATA_W - SPW_CNT_W;

   localparam logic [SPW_CNT_W-1:0] MIDSCALE = {1'b1, {(SPW_CNT_W-1){1'b0}}};

   // Two's complement to offset binary, keeping the top CNT_W bits.
   function automatic logic [SPW_CNT_W-1:0] to_duty(input logic signed [SPW_DATA_W-1:0] sample);
      logic [SPW_DATA_W-1:0] ofs;
      ofs = sample ^ {1'b1, {(SPW_DATA_W-1){1'b0}}};
      return ofs[SPW_DATA_W-1 -: SPW_CNT_W];
   endfunction

   function automatic logic [FRAC_W-1:0] to_frac(input logic signed [SPW_DATA_W-1:0] sample);
      logic [SPW_DATA_W-1:0] ofs;
      ofs = sample ^ {1'b1, {(SPW_DATA_W-1){1'b0}}};
      return ofs[FRAC_W-1:0];
   endfunction

endpackage

// File: rtl/sin_pwm_dac_core.sv
// Free-running PWM period counter with a registered duty comparator.
// DUTY_W may be one bit wider than the counter so that a full-scale duty stays high all period.
module sin_pwm_core
   import sin_pwm_pkg::*;
#(
   parameter int CNT_W  = SPW_CNT_W,
   parameter int DUTY_W = SPW_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] duty,
   output logic              pwm_out,
   output logic              period_start,
   output logic              boundary
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         pwm_out <= 1'b0;
      end else begin
         cnt     <= cnt + CNT_W'(1);
         pwm_out <= (DUTY_W'(cnt) < duty);
      end
   end

   assign period_start = (cnt == '0);
   assign boundary     = &cnt;

endmodule

// File: rtl/sin_pwm_dac.sv
// Signed-sample to PWM DAC: one-entry holding buffer, period-boundary load/bypass, sticky underrun.
// Define SIN_PWM_DITHER_EN to dither the truncated sample LSBs into the duty across periods.
module sin_pwm_dac
   import sin_pwm_pkg::*;
#(
   parameter int DATA_W = SPW_DATA_W,
   parameter int CNT_W  = SPW_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     pwm_out,
   output logic                     period_start,
   output logic                     underrun
);

`ifdef SIN_PWM_DITHER_EN
   localparam int DUTY_W = CNT_W + 1;
`else
   localparam int DUTY_W = CNT_W;
`endif

   logic              pending_full;
   logic [CNT_W-1:0]  pending_duty;
   logic [CNT_W-1:0]  active_duty;
   logic [CNT_W-1:0]  in_duty;
   logic [CNT_W-1:0]  next_duty;
   logic [DUTY_W-1:0] core_duty;
   logic              boundary;
   logic              accept;

   assign in_duty  = to_duty(in_data);
   assign in_ready = !pending_full;
   assign accept   = in_valid & in_ready;

   // Buffered sample wins; otherwise a sample offered on the boundary bypasses the buffer.
   always_comb begin
      next_duty = active_duty;
      if (pending_full)
         next_duty = pending_duty;
      else if (in_valid)
         next_duty = in_duty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_full <= 1'b0;
         pending_duty <= '0;
         active_duty  <= MIDSCALE;
         underrun     <= 1'b0;
      end else if (boundary) begin
         pending_full <= 1'b0;
         active_duty  <= next_duty;
         if (!pending_full && !in_valid)
            underrun <= 1'b1;
      end else if (accept) begin
         pending_full <= 1'b1;
         pending_duty <= in_duty;
      end
   end

`ifdef SIN_PWM_DITHER_EN
   logic [FRAC_W-1:0] pending_frac;
   logic [FRAC_W-1:0] active_frac;
   logic [FRAC_W-1:0] next_frac;
   logic [FRAC_W-1:0] acc;
   logic [FRAC_W:0]   frac_sum;
   logic [DUTY_W-1:0] duty_eff;

   always_comb begin
      next_frac = active_frac;
      if (pending_full)
         next_frac = pending_frac;
      else if (in_valid)
         next_frac = to_frac(in_data);
   end

   assign frac_sum = {1'b0, acc} + {1'b0, next_frac};

   // Carry out of the residual accumulator stretches this period by one count.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_frac <= '0;
         active_frac  <= '0;
         acc          <= '0;
         duty_eff     <= {1'b0, MIDSCALE};
      end else if (boundary) begin
         active_frac <= next_frac;
         acc         <= frac_sum[FRAC_W-1:0];
         duty_eff    <= {1'b0, next_duty} + DUTY_W'(frac_sum[FRAC_W]);
      end else if (accept) begin
         pending_frac <= to_frac(in_data);
      end
   end

   assign core_duty = duty_eff;
`else
   assign core_duty = active_duty;
`endif

   sin_pwm_core #(
      .CNT_W  (CNT_W),
      .DUTY_W (DUTY_W)
   ) u_core (
      .clk          (clk),
      .rst          (rst),
      .duty         (core_duty),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .boundary     (boundary)
   );

endmodule

// File: tb/tb_sin_pwm_dac.sv
// Directed bench for sin_pwm_dac (CNT_W=8): duty per period, handshake, bypass, underrun, reset.
module tb_sin_pwm_dac;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [15:0] in_data;
   logic               in_valid;
   logic               in_ready;
   logic               pwm_out;
   logic               period_start;
   logic               underrun;

   int n_cmp = 0;
   int n_bad = 0;

   sin_pwm_dac dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Starts at a negedge with cnt==0; ends at the negedge where cnt is 0 again.
   // pwm_out lags cnt by one, so these 256 samples cover exactly one period.
   task automatic run_period(input bit feed, input logic [15:0] sample, input int at,
                             output int hi, output int rdy_after);
      hi        = 0;
      rdy_after = -1;
      for (int i = 0; i < 256; i++) begin
         if (feed && i == at) begin
            in_valid = 1'b1;
            in_data  = sample;
         end
         @(posedge clk);
         @(negedge clk);
         if (feed && i == at) begin
            in_valid  = 1'b0;
            rdy_after = int'(in_ready);
         end
         hi += int'(pwm_out);
      end
   endtask

   int hi, rdy, acc_cnt;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_pwm_out", int'(pwm_out), 0);
      check("rst_period_start", int'(period_start), 1);
      check("rst_underrun", int'(underrun), 0);
      rst = 1'b0;

      // Idle after reset: midscale, underrun at first boundary
      run_period(1'b0, 16'h0000, 0, hi, rdy);
      check("idle_hi", hi, 128);
      check("idle_underrun", int'(underrun), 1);
      check("idle_period_start", int'(period_start), 1);

      // Full-scale, zero-scale and midscale samples
      do_reset();
      check("seq_underrun0", int'(underrun), 0);
      run_period(1'b1, 16'h7FFF, 10, hi, rdy);
      check("seq_p1_hi", hi, 128);
      check("seq_p1_ready_after_accept", rdy, 0);
      run_period(1'b1, 16'h8000, 10, hi, rdy);
      check("seq_p2_hi", hi, 255);
      run_period(1'b1, 16'h0000, 10, hi, rdy);
      check("seq_p3_hi", hi, 0);
      check("seq_underrun_fed", int'(underrun), 0);
      run_period(1'b0, 16'h0000, 0, hi, rdy);
      check("seq_p4_hi", hi, 128);
      check("seq_underrun_starved", int'(underrun), 1);

      // in_valid held high with a ramp: one accept per period
      do_reset();
      in_valid = 1'b1;
      in_data  = 16'sh8000;
      for (int p = 0; p < 3; p++) begin
         hi      = 0;
         acc_cnt = 0;
         check("ramp_ready_at_cnt0", int'(in_ready), 1);
         for (int i = 0; i < 256; i++) begin
            bit took;
            took = in_valid && in_ready;
            if (took) acc_cnt++;
            if (i == 255) check("ramp_ready_at_cnt255", int'(in_ready), 0);
            @(posedge clk);
            @(negedge clk);
            if (took) in_data = in_data + 16'sh4000;
            hi += int'(pwm_out);
         end
         check("ramp_accepts", acc_cnt, 1);
         check("ramp_hi", hi, (p == 0) ? 128 : (p == 1) ? 0 : 64);
      end
      in_valid = 1'b0;
      check("ramp_underrun", int'(underrun), 0);

      // Sample offered only on the boundary bypasses the buffer
      do_reset();
      run_period(1'b1, 16'h4000, 255, hi, rdy);
      check("bypass_p1_hi", hi, 128);
      check("bypass_ready_after", rdy, 1);
      check("bypass_underrun", int'(underrun), 0);
      run_period(1'b0, 16'h0000, 0, hi, rdy);
      check("bypass_p2_hi", hi, 192);
      check("bypass_underrun_later", int'(underrun), 1);

      // Reset mid-period with the buffer full
      for (int i = 0; i < 100; i++) begin
         in_valid = (i == 10);
         in_data  = 16'sh7FFF;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("midrst_pending_full", int'(in_ready), 0);
      check("midrst_not_cnt0", int'(period_start), 0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_period_start", int'(period_start), 1);
      check("midrst_in_ready", int'(in_ready), 1);
      check("midrst_underrun", int'(underrun), 0);
      check("midrst_pwm_out", int'(pwm_out), 0);
      run_period(1'b0, 16'h0000, 0, hi, rdy);
      check("midrst_hi", hi, 128);
      check("midrst_pending_dropped", int'(underrun), 1);

      // Constant 0x0080: dithered 128/129 alternation, plain 128
      do_reset();
      run_period(1'b1, 16'h0080, 10, hi, rdy);
      check("dith_p0_hi", hi, 128);
      run_period(1'b1, 16'h0080, 10, hi, rdy);
      check("dith_p1_hi", hi, 128);
      run_period(1'b1, 16'h0080, 10, hi, rdy);
`ifdef SIN_PWM_DITHER_EN
      check("dith_p2_hi", hi, 129);
`else
      check("dith_p2_hi", hi, 128);
`endif
      run_period(1'b1, 16'h0080, 10, hi, rdy);
      check("dith_p3_hi", hi, 128);
      check("dith_underrun", int'(underrun), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
